// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, drives the combinational imem address, fills IF/ID.
// Optional perf counters are enabled with `define IF_PERF_COUNTERS_EN.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 112,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_misalign_o,
  output logic        imem_oob_o
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_bubbles_o
`endif
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        do_redir;
  logic        do_bubble;
  logic        do_hold;
  logic        do_load;

  // Per-edge action; redirect beats flush beats stall.
  always_comb begin
    do_redir  = redirect_valid_i;
    do_bubble = redirect_valid_i | flush_i;
    do_hold   = ~do_bubble & stall_i;
    do_load   = ~do_bubble & ~stall_i;
  end

  // Next PC selection.
  always_comb begin
    pc_next = pc + 32'd4;
    unique case (1'b1)
      do_redir: pc_next = {redirect_target_i[31:2], 2'b00};
      do_hold:  pc_next = pc;
      default:  pc_next = pc + 32'd4;
    endcase
  end

  assign imem_addr_o = pc;
  assign imem_oob_o  = (pc >= IMEM_LIMIT);

  // PC and IF/ID register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc               <= RESET_PC;
      if_id_valid_o    <= 1'b0;
      if_id_pc_o       <= 32'd0;
      if_id_instr_o    <= NOP_INSTR;
      if_id_misalign_o <= 1'b0;
    end else begin
      pc <= pc_next;
      if (do_bubble) begin
        if_id_valid_o    <= 1'b0;
        if_id_pc_o       <= 32'd0;
        if_id_instr_o    <= NOP_INSTR;
        if_id_misalign_o <= do_redir & (|redirect_target_i[1:0]);
      end else if (do_load) begin
        if_id_valid_o    <= 1'b1;
        if_id_pc_o       <= pc;
        if_id_instr_o    <= imem_instr_i;
        if_id_misalign_o <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_COUNTERS_EN
  // Fetch/bubble counters; stall edges count in neither.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_o <= 32'd0;
      perf_bubbles_o <= 32'd0;
    end else begin
      if (do_load)
        perf_fetched_o <= perf_fetched_o + 32'd1;
      if (do_bubble)
        perf_bubbles_o <= perf_bubbles_o + 32'd1;
    end
  end
`endif

endmodule
